// File: rtl/spi_pkg.sv
// Shared definitions for the SPI read master and its slave-side test models.
// Holds the FSM state encoding and the default timing parameters.
package spi_pkg;

  localparam int unsigned HalfPeriodDefault = 8;
  localparam int unsigned GapCyclesDefault  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAddr,
    StGap,
    StData,
    StHold
  } spi_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period timer with a registered SCK that idles low.
// rise_o/fall_o flag the cycle whose clock edge makes SCK rise/fall.
module spi_sck_gen #(
  parameter int unsigned HALF_PERIOD = spi_pkg::HalfPeriodDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned TimerW = $clog2(HALF_PERIOD);

  logic [TimerW-1:0] timer_q, timer_d;
  logic              sck_q, sck_d;
  logic              wrap;

  assign wrap   = en_i && (timer_q == TimerW'(HALF_PERIOD - 1));
  assign rise_o = wrap && !sck_q;
  assign fall_o = wrap && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    timer_d = timer_q;
    sck_d   = sck_q;
    if (clr_i) begin
      timer_d = '0;
      sck_d   = 1'b0;
    end else if (wrap) begin
      timer_d = '0;
      sck_d   = ~sck_q;
    end else if (en_i) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q <= '0;
      sck_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      sck_q   <= sck_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI read master: sends an 8-bit start address, then reads i_len bytes,
// leaving a fixed gap before each byte for the slave's fetch latency.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HalfPeriodDefault,
  parameter int unsigned GAP_CYCLES  = GapCyclesDefault
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_addr,
  input  logic [3:0] i_len,
  input  logic       i_miso,
  output logic       o_sck,
  output logic       o_en_n,
  output logic       o_mosi,
  output logic [7:0] o_data,
  output logic       o_data_vld,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CntMax = max_u(HALF_PERIOD, GAP_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax);

  spi_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [3:0]      byte_q;
  logic [7:0]      tx_sr_q;
  logic [7:0]      rx_sr_q;
  logic [7:0]      data_q;
  logic            en_n_q, mosi_q, data_vld_q, busy_q, done_q;
  logic            sck_en, sck_clr, sck_rise, sck_fall;

  assign sck_en  = (state_q == StAddr) || (state_q == StData);
  assign sck_clr = !sck_en;

  spi_sck_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sck_gen (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .en_i  (sck_en),
    .clr_i (sck_clr),
    .sck_o (o_sck),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      data_q     <= '0;
      en_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      data_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      data_vld_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            tx_sr_q <= i_addr;
            byte_q  <= i_len;
            en_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == CntW'(HALF_PERIOD - 1)) begin
            // First address bit goes out with the first low phase of ADDR.
            cnt_q   <= '0;
            bit_q   <= '0;
            mosi_q  <= tx_sr_q[7];
            tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            state_q <= StAddr;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StAddr: begin
          if (sck_fall) begin
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              mosi_q  <= 1'b0;
              state_q <= (byte_q == 4'd0) ? StHold : StGap;
            end else begin
              bit_q   <= bit_q + 1'b1;
              mosi_q  <= tx_sr_q[7];
              tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end
          end
        end
        StGap: begin
          if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          // Sample on the edge where SCK rises; slave shifts after it.
          if (sck_rise) begin
            rx_sr_q <= {rx_sr_q[6:0], i_miso};
          end
          if (sck_fall) begin
            if (bit_q == 3'd7) begin
              bit_q      <= '0;
              data_q     <= rx_sr_q;
              data_vld_q <= 1'b1;
              byte_q     <= byte_q - 1'b1;
              state_q    <= (byte_q == 4'd1) ? StHold : StGap;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (cnt_q == CntW'(HALF_PERIOD - 1)) begin
            cnt_q   <= '0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_en_n     = en_n_q;
  assign o_mosi     = mosi_q;
  assign o_data     = data_q;
  assign o_data_vld = data_vld_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 8: i_clk cycles per SCK half-period; legal range 4..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 16: i_clk cycles with SCK low and CS asserted before each data byte.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 SHALL have port i_addr  input  8  start address, sent MSB-first.
REQ-007 SHALL have port i_len  input  4  number of data bytes to read, 0..15.
REQ-008 SHALL have port i_miso  input  1  serial data from the slave.
REQ-009 SHALL have port o_sck  output  1  SPI clock; idles low.
REQ-010 SHALL have port o_en_n  output  1  chip select, active-low.
REQ-011 SHALL have port o_mosi  output  1  serial address to the slave.
REQ-012 SHALL have ports o_data (output, 8 bits, received byte) and o_data_vld (output, 1 bit, one-cycle strobe for o_data).
REQ-013 SHALL have ports o_busy (output, 1 bit, high outside IDLE) and o_done (output, 1 bit, one-cycle end-of-transaction pulse).

Function
REQ-014 SHALL use states IDLE, SETUP, ADDR, GAP, DATA, HOLD.
REQ-015 IDLE: when i_start=1, SHALL latch i_addr and i_len, drive o_en_n=0 on the next cycle, and enter SETUP.
REQ-016 SETUP SHALL last HALF_PERIOD cycles with o_sck=0, then enter ADDR.
REQ-017 Bit period SHALL be a low phase of HALF_PERIOD cycles followed by a high phase of HALF_PERIOD cycles.
REQ-018 o_mosi SHALL update in the first cycle of each low phase and SHALL hold stable through the following high phase.
REQ-019 ADDR SHALL send 8 bits, address bit 7 first.
REQ-020 After ADDR, if the latched length is 0 the block SHALL enter HOLD; otherwise it SHALL enter GAP.
REQ-021 GAP SHALL last GAP_CYCLES cycles with o_sck=0 and o_mosi=0, then enter DATA. Purpose: slave ROM fetch and CS/SCK synchroniser latency.
REQ-022 DATA SHALL clock 8 bit periods with o_mosi=0.
REQ-023 In DATA, i_miso SHALL be sampled in the same cycle o_sck rises, because the slave shifts on the rising edge and bit 7 is valid before the first rise.
REQ-024 Received bits SHALL be shifted in MSB-first.
REQ-025 After the 8th DATA bit, o_data SHALL load the byte and o_data_vld SHALL pulse for 1 cycle.
REQ-026 After each byte, the remaining count SHALL decrement; if it is nonzero the block SHALL re-enter GAP, else enter HOLD.
REQ-027 HOLD SHALL last HALF_PERIOD cycles with o_sck=0, then drive o_en_n=1, pulse o_done for 1 cycle, and return to IDLE.
REQ-028 i_start outside IDLE SHALL be ignored, with no queuing.
REQ-029 o_data SHALL hold its value until the next o_data_vld.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-031 Timer and bit counters SHALL be sized for their maximum count with no wrap-around; the byte counter is 4 bits and counts down from i_len.

Reset
REQ-032 While i_rst_n=0 at a clock edge, the block SHALL enter IDLE with o_sck=0, o_en_n=1, o_mosi=0, o_data=0, o_data_vld=0, o_busy=0, o_done=0, and all counters 0.
REQ-033 Reset mid-transaction SHALL abort immediately: o_en_n=1 and o_sck=0 from the cycle after the reset edge, with no o_data_vld and no o_done.

Structure
REQ-034 Package spi_pkg SHALL hold the state encodings and default HALF_PERIOD and GAP_CYCLES, shared with the slave testbench.
REQ-035 Sub-module spi_sck_gen SHALL hold the half-period timer and o_sck toggle, with enable/clear inputs and rise/fall strobes.
REQ-036 The top level SHALL hold the FSM, shift registers and byte counter.

Verification
REQ-037 Scenario: i_addr=0x41, i_len=1, slave model ROM[0x41]=0x41 -> o_mosi bits 0,1,0,0,0,0,0,1, exactly 16 SCK rises, o_data=0x41 with one o_data_vld, then o_done.
REQ-038 Scenario: i_addr=0xFE, i_len=3, ROM[n]=n -> o_data sequence 0xFE, 0xFF, 0x00 (slave address wrap), and o_en_n low throughout.
REQ-039 Scenario: i_len=0, i_addr=0x80 -> 8 SCK rises only, no o_data_vld, then o_done; o_en_n low for exactly 2*HALF_PERIOD*8 + 2*HALF_PERIOD cycles (plus the SETUP/HOLD boundary cycles).
REQ-040 Scenario: i_start pulsed again mid-ADDR with a different i_addr -> ignored; the original transaction completes unchanged.
REQ-041 Scenario: i_rst_n=0 during the 4th DATA bit -> the next cycle shows o_en_n=1, o_sck=0, o_busy=0, and no o_done.
REQ-042 Scenario: HALF_PERIOD=4 with the slave model double-flopping SCK -> all bytes received correctly.
